// File: rtl/gbe_rx_udp_if.sv
// MAC receive byte stream into the UDP parser and the application payload stream out of it.
interface gbe_rx_udp_if;
    logic [7:0]  mac_rx_data;
    logic        mac_rx_dvld;
    logic        mac_rx_goodframe;
    logic        mac_rx_badframe;
    logic [7:0]  app_data;
    logic        app_dvld;
    logic        app_eof;
    logic        app_bad;
    logic [31:0] app_srcip;
    logic [15:0] app_srcport;
    logic [15:0] rx_drop_count;

    modport master (
        output mac_rx_data, mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe,
        input  app_data, app_dvld, app_eof, app_bad, app_srcip, app_srcport, rx_drop_count
    );
    modport slave (
        input  mac_rx_data, mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe,
        output app_data, app_dvld, app_eof, app_bad, app_srcip, app_srcport, rx_drop_count
    );
endinterface

// File: rtl/gbe_rx_udp.sv
// Receive UDP/IPv4 parser: filters Ethernet/IP/UDP headers and forwards the UDP payload.
// Optional IPv4 header checksum verification is enabled with `define GBE_RX_CSUM_EN.
module gbe_rx_udp #(
    parameter bit ACCEPT_BCAST = 1'b1
) (
    input  logic        mac_clk,
    input  logic        mac_rst_n,
    input  logic        local_enable,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [15:0] local_port,
    gbe_rx_udp_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HDR_MAC, HDR_IP, HDR_UDP, DATA, SKIP} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] pay_q, pay_d, len_q, len_d;
    logic [31:0] sip_q, sip_d;
    logic [15:0] sport_q, sport_d;
    logic        mac_ne_q, mac_ne_d, bc_ne_q, bc_ne_d, rej_q, rej_d, fwd_q, fwd_d;
    logic        prev_dvld_q;
    logic [7:0]  data_q, data_d;
    logic        dvld_q, dvld_d, eof_q, eof_d, bad_q, bad_d;
    logic [31:0] srcip_q, srcip_d;
    logic [15:0] srcport_q, srcport_d, drop_q, drop_d;
    logic        drop_inc, csum_bad, mac_fail;
    logic [7:0]  rxd, mac_b, ip_b, port_b;
    logic        rxv;

    assign rxd = bus.mac_rx_data;
    assign rxv = bus.mac_rx_dvld;
    assign mac_fail = mac_ne_q & (~ACCEPT_BCAST | bc_ne_q);

    always_comb begin
        mac_b = local_mac[7:0];
        case (cnt_q[2:0])
            3'd0: mac_b = local_mac[47:40];
            3'd1: mac_b = local_mac[39:32];
            3'd2: mac_b = local_mac[31:24];
            3'd3: mac_b = local_mac[23:16];
            3'd4: mac_b = local_mac[15:8];
            default: mac_b = local_mac[7:0];
        endcase
        ip_b = local_ip[7:0];
        case (cnt_q[1:0])
            2'd0: ip_b = local_ip[31:24];
            2'd1: ip_b = local_ip[23:16];
            2'd2: ip_b = local_ip[15:8];
            default: ip_b = local_ip[7:0];
        endcase
        port_b = cnt_q[0] ? local_port[7:0] : local_port[15:8];
    end

`ifdef GBE_RX_CSUM_EN
    logic [15:0] csum_q, csum_d;
    logic [7:0]  chi_q, chi_d;
    logic [16:0] csum_sum;

    // Ones-complement running sum of the IP header words, end-around carry folded each add.
    always_comb begin
        csum_d   = csum_q;
        chi_d    = chi_q;
        csum_sum = {1'b0, csum_q} + {1'b0, chi_q, rxd};
        if (state_q == IDLE) begin
            csum_d = '0;
        end else if (state_q == HDR_IP && rxv) begin
            if (!cnt_q[0]) chi_d = rxd;
            else           csum_d = csum_sum[15:0] + {15'd0, csum_sum[16]};
        end
    end
    assign csum_bad = (csum_q != 16'hFFFF);

    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            csum_q <= '0;
            chi_q  <= '0;
        end else begin
            csum_q <= csum_d;
            chi_q  <= chi_d;
        end
    end
`else
    assign csum_bad = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 6'd1;
        pay_d     = pay_q;
        len_d     = len_q;
        sip_d     = sip_q;
        sport_d   = sport_q;
        mac_ne_d  = mac_ne_q;
        bc_ne_d   = bc_ne_q;
        rej_d     = rej_q;
        fwd_d     = fwd_q;
        data_d    = data_q;
        dvld_d    = 1'b0;
        eof_d     = 1'b0;
        bad_d     = 1'b0;
        srcip_d   = srcip_q;
        srcport_d = srcport_q;
        drop_inc  = 1'b0;

        // FCS verdict for a frame whose payload was already handed out.
        if (bus.mac_rx_badframe && fwd_q) begin
            bad_d = 1'b1;
            fwd_d = 1'b0;
        end
        if (bus.mac_rx_goodframe) fwd_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rxv) begin
                    // dvld already high on the previous cycle means we joined mid-frame.
                    if (prev_dvld_q || !local_enable) begin
                        state_d = SKIP;
                    end else begin
                        state_d  = HDR_MAC;
                        cnt_d    = 6'd1;
                        fwd_d    = 1'b0;
                        rej_d    = 1'b0;
                        mac_ne_d = (rxd != local_mac[47:40]);
                        bc_ne_d  = (rxd != 8'hFF);
                    end
                end
            end
            HDR_MAC: begin
                if (!rxv) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end else begin
                    if (cnt_q < 6'd6) begin
                        mac_ne_d = mac_ne_q | (rxd != mac_b);
                        bc_ne_d  = bc_ne_q | (rxd != 8'hFF);
                    end
                    if (cnt_q == 6'd12) rej_d = rej_q | (rxd != 8'h08);
                    if (cnt_q == 6'd13) begin
                        rej_d   = rej_q | (rxd != 8'h00);
                        state_d = HDR_IP;
                        cnt_d   = 6'd0;
                    end
                end
            end
            HDR_IP: begin
                if (!rxv) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end else begin
                    case (cnt_q)
                        6'd0:  rej_d = rej_q | (rxd != 8'h45);
                        6'd6:  rej_d = rej_q | ((rxd & 8'h3F) != 8'h00);
                        6'd7:  rej_d = rej_q | (rxd != 8'h00);
                        6'd9:  rej_d = rej_q | (rxd != 8'h11);
                        6'd12, 6'd13, 6'd14, 6'd15: sip_d = {sip_q[23:0], rxd};
                        6'd16, 6'd17, 6'd18: rej_d = rej_q | (rxd != ip_b);
                        6'd19: begin
                            rej_d   = rej_q | (rxd != ip_b);
                            state_d = HDR_UDP;
                            cnt_d   = 6'd0;
                        end
                        default: ;
                    endcase
                end
            end
            HDR_UDP: begin
                if (!rxv) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end else begin
                    case (cnt_q)
                        6'd0: begin
                            sport_d = {sport_q[7:0], rxd};
                            rej_d   = rej_q | csum_bad;
                        end
                        6'd1: sport_d = {sport_q[7:0], rxd};
                        6'd2, 6'd3: rej_d = rej_q | (rxd != port_b);
                        6'd4, 6'd5: len_d = {len_q[7:0], rxd};
                        6'd7: begin
                            if (rej_q || mac_fail || len_q < 16'd8) begin
                                drop_inc = 1'b1;
                                state_d  = SKIP;
                            end else if (len_q == 16'd8) begin
                                state_d = SKIP;
                            end else begin
                                pay_d   = len_q - 16'd8;
                                state_d = DATA;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            DATA: begin
                if (rxv) begin
                    dvld_d = 1'b1;
                    data_d = rxd;
                    // Source fields change only with the first byte of a new payload.
                    if (!fwd_q) begin
                        srcip_d   = sip_q;
                        srcport_d = sport_q;
                    end
                    fwd_d = 1'b1;
                    pay_d = pay_q - 16'd1;
                    if (pay_q == 16'd1) begin
                        eof_d   = 1'b1;
                        state_d = SKIP;
                    end
                end else begin
                    bad_d    = 1'b1;
                    fwd_d    = 1'b0;
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            SKIP: if (!rxv) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        drop_d = drop_q;
        if (drop_inc && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge mac_clk or negedge mac_rst_n) begin
        if (!mac_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pay_q       <= '0;
            len_q       <= '0;
            sip_q       <= '0;
            sport_q     <= '0;
            mac_ne_q    <= 1'b0;
            bc_ne_q     <= 1'b0;
            rej_q       <= 1'b0;
            fwd_q       <= 1'b0;
            prev_dvld_q <= 1'b1;
            data_q      <= '0;
            dvld_q      <= 1'b0;
            eof_q       <= 1'b0;
            bad_q       <= 1'b0;
            srcip_q     <= '0;
            srcport_q   <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pay_q       <= pay_d;
            len_q       <= len_d;
            sip_q       <= sip_d;
            sport_q     <= sport_d;
            mac_ne_q    <= mac_ne_d;
            bc_ne_q     <= bc_ne_d;
            rej_q       <= rej_d;
            fwd_q       <= fwd_d;
            prev_dvld_q <= rxv;
            data_q      <= data_d;
            dvld_q      <= dvld_d;
            eof_q       <= eof_d;
            bad_q       <= bad_d;
            srcip_q     <= srcip_d;
            srcport_q   <= srcport_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.app_data      = data_q;
    assign bus.app_dvld      = dvld_q;
    assign bus.app_eof       = eof_q;
    assign bus.app_bad       = bad_q;
    assign bus.app_srcip     = srcip_q;
    assign bus.app_srcport   = srcport_q;
    assign bus.rx_drop_count = drop_q;
endmodule

// File: tb/tb_gbe_rx_udp.sv
// Scoreboard bench for gbe_rx_udp: directed frames, payload bytes checked by a monitor.
module tb_gbe_rx_udp;
    localparam logic [47:0] MYMAC = 48'h02_00_00_00_00_02;
    localparam logic [31:0] MYIP  = 32'h0a_00_00_02;
    localparam logic [15:0] PORT  = 16'd7148;
    localparam logic [31:0] SIP   = 32'h0a_00_00_01;
    localparam logic [15:0] SPORT = 16'h1234;

    logic        mac_clk = 1'b0;
    logic        mac_rst_n = 1'b0;
    logic        local_enable;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic [15:0] local_port;

    always #5 mac_clk = ~mac_clk;

    gbe_rx_udp_if bus();

    gbe_rx_udp #(.ACCEPT_BCAST(1'b1)) dut (
        .mac_clk      (mac_clk),
        .mac_rst_n    (mac_rst_n),
        .local_enable (local_enable),
        .local_mac    (local_mac),
        .local_ip     (local_ip),
        .local_port   (local_port),
        .bus          (bus)
    );

    typedef struct packed {
        logic [7:0]  d;
        logic        eof;
        logic [31:0] sip;
        logic [15:0] sp;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] frm[$];
    int checks = 0, errors = 0;
    int dvld_seen = 0, eof_seen = 0, bad_seen = 0;
    int exp_dvld = 0, exp_eof = 0, exp_bad = 0, exp_drop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every delivered byte must match the head of the scoreboard queue.
    always @(negedge mac_clk) begin
        if (mac_rst_n) begin
            if (bus.app_dvld) begin
                dvld_seen++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte got=%0h expected=none", bus.app_data);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("payload", {7'd0, bus.app_data, bus.app_eof, bus.app_srcip, bus.app_srcport}, {7'd0, e});
                end
            end
            if (bus.app_eof) eof_seen++;
            if (bus.app_bad) bad_seen++;
        end
    end

    task automatic build(input logic [47:0] dmac, input logic [7:0] proto, input logic [31:0] dip,
                         input logic [15:0] dport, input logic [15:0] ulen, input logic [7:0] base,
                         input bit bad_ck);
        logic [47:0] smac;
        logic [15:0] tl, ck;
        logic [31:0] s;
        smac = 48'h02_00_00_00_00_01;
        tl   = ulen + 16'd20;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dmac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(smac[47-8*i -: 8]);
        frm.push_back(8'h08); frm.push_back(8'h00);
        frm.push_back(8'h45); frm.push_back(8'h00); frm.push_back(tl[15:8]); frm.push_back(tl[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h01); frm.push_back(8'h40); frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(proto); frm.push_back(8'h00); frm.push_back(8'h00);
        for (int i = 0; i < 4; i++) frm.push_back(SIP[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) frm.push_back(dip[31-8*i -: 8]);
        s = 32'd0;
        for (int i = 0; i < 10; i++) s = s + {16'd0, frm[14+2*i], frm[15+2*i]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        ck = ~s[15:0];
        if (bad_ck) ck = ck ^ 16'h0100;
        frm[24] = ck[15:8];
        frm[25] = ck[7:0];
        frm.push_back(SPORT[15:8]); frm.push_back(SPORT[7:0]);
        frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
        frm.push_back(ulen[15:8]);  frm.push_back(ulen[7:0]);
        frm.push_back(8'h00);       frm.push_back(8'h00);
        for (int i = 0; i < int'(ulen) - 8; i++) frm.push_back(base + 8'(i));
        while (frm.size() < 60) frm.push_back(8'h00);
    endtask

    task automatic push_exp(input logic [7:0] base, input int n, input bit with_eof);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.d   = base + 8'(i);
            e.eof = with_eof && (i == n - 1);
            e.sip = SIP;
            e.sp  = SPORT;
            expq.push_back(e);
        end
        exp_dvld += n;
        if (with_eof) exp_eof++;
    endtask

    // pulse: 0 none, 1 goodframe, 2 badframe
    task automatic send(input int nbytes, input int pulse);
        for (int i = 0; i < nbytes; i++) begin
            @(posedge mac_clk); #1;
            bus.mac_rx_dvld = 1'b1;
            bus.mac_rx_data = frm[i];
        end
        @(posedge mac_clk); #1;
        bus.mac_rx_dvld      = 1'b0;
        bus.mac_rx_data      = 8'h00;
        bus.mac_rx_goodframe = (pulse == 1);
        bus.mac_rx_badframe  = (pulse == 2);
        @(posedge mac_clk); #1;
        bus.mac_rx_goodframe = 1'b0;
        bus.mac_rx_badframe  = 1'b0;
        if (pulse == 2) begin
            @(negedge mac_clk);
            chk("bad_pulse_timing", {63'd0, bus.app_bad}, 64'd1);
        end
    endtask

    task automatic settle_and_check(input string tag);
        repeat (4) @(posedge mac_clk);
        @(negedge mac_clk);
        chk({tag, "_queue_empty"}, 64'(expq.size()), 64'd0);
        chk({tag, "_dvld_count"}, 64'(dvld_seen), 64'(exp_dvld));
        chk({tag, "_eof_count"}, 64'(eof_seen), 64'(exp_eof));
        chk({tag, "_bad_count"}, 64'(bad_seen), 64'(exp_bad));
        chk({tag, "_drop_count"}, {48'd0, bus.rx_drop_count}, 64'(exp_drop));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.mac_rx_data      = 8'h00;
        bus.mac_rx_dvld      = 1'b0;
        bus.mac_rx_goodframe = 1'b0;
        bus.mac_rx_badframe  = 1'b0;
        local_enable = 1'b1;
        local_mac    = MYMAC;
        local_ip     = MYIP;
        local_port   = PORT;
        repeat (3) @(posedge mac_clk);
        @(negedge mac_clk);
        chk("rst_data",    {56'd0, bus.app_data}, 64'd0);
        chk("rst_dvld",    {63'd0, bus.app_dvld}, 64'd0);
        chk("rst_eof",     {63'd0, bus.app_eof}, 64'd0);
        chk("rst_bad",     {63'd0, bus.app_bad}, 64'd0);
        chk("rst_srcip",   {32'd0, bus.app_srcip}, 64'd0);
        chk("rst_srcport", {48'd0, bus.app_srcport}, 64'd0);
        chk("rst_drop",    {48'd0, bus.rx_drop_count}, 64'd0);
        @(posedge mac_clk); #1;
        mac_rst_n = 1'b1;

        // Valid frame, 32-byte payload.
        build(MYMAC, 8'h11, MYIP, PORT, 16'd40, 8'h10, 1'b0);
        push_exp(8'h10, 32, 1'b1);
        send(frm.size(), 1);
        settle_and_check("valid");

        // Wrong port, wrong MAC, TCP protocol: all rejected.
        build(MYMAC, 8'h11, MYIP, PORT + 16'd1, 16'd40, 8'h10, 1'b0);
        send(frm.size(), 1);
        build(48'h02_00_00_00_00_99, 8'h11, MYIP, PORT, 16'd40, 8'h10, 1'b0);
        send(frm.size(), 1);
        build(MYMAC, 8'h06, MYIP, PORT, 16'd40, 8'h10, 1'b0);
        send(frm.size(), 1);
        exp_drop = 3;
        settle_and_check("rejects");

        // 4-byte payload in a padded 60-byte frame.
        build(MYMAC, 8'h11, MYIP, PORT, 16'd12, 8'h50, 1'b0);
        push_exp(8'h50, 4, 1'b1);
        send(frm.size(), 1);
        settle_and_check("padded");

        // Full payload, then bad FCS.
        build(MYMAC, 8'h11, MYIP, PORT, 16'd40, 8'h80, 1'b0);
        push_exp(8'h80, 32, 1'b1);
        exp_bad++;
        send(frm.size(), 2);
        settle_and_check("badfcs");

        // Truncated after 10 payload bytes.
        build(MYMAC, 8'h11, MYIP, PORT, 16'd40, 8'hC0, 1'b0);
        push_exp(8'hC0, 10, 1'b0);
        exp_bad++;
        exp_drop++;
        send(42 + 10, 0);
        settle_and_check("trunc");

        // Broadcast destination accepted.
        build(48'hFF_FF_FF_FF_FF_FF, 8'h11, MYIP, PORT, 16'd10, 8'hE0, 1'b0);
        push_exp(8'hE0, 2, 1'b1);
        send(frm.size(), 1);
        settle_and_check("bcast");

        // Zero-length payload: nothing forwarded, not a drop.
        build(MYMAC, 8'h11, MYIP, PORT, 16'd8, 8'h00, 1'b0);
        send(frm.size(), 1);
        settle_and_check("len8");

        // Corrupted IP header checksum.
        build(MYMAC, 8'h11, MYIP, PORT, 16'd16, 8'h20, 1'b1);
`ifdef GBE_RX_CSUM_EN
        exp_drop++;
`else
        push_exp(8'h20, 8, 1'b1);
`endif
        send(frm.size(), 1);
        settle_and_check("csum");

        // Disabled receiver: ignored without counting a drop.
        local_enable = 1'b0;
        build(MYMAC, 8'h11, MYIP, PORT, 16'd40, 8'h10, 1'b0);
        send(frm.size(), 1);
        local_enable = 1'b1;
        settle_and_check("disabled");

        // Reset mid-payload after 6 payload bytes; the 6th never reaches the monitor.
        build(MYMAC, 8'h11, MYIP, PORT, 16'd40, 8'h30, 1'b0);
        push_exp(8'h30, 5, 1'b0);
        for (int i = 0; i < 42 + 6; i++) begin
            @(posedge mac_clk); #1;
            bus.mac_rx_dvld = 1'b1;
            bus.mac_rx_data = frm[i];
        end
        @(posedge mac_clk); #1;
        mac_rst_n = 1'b0;
        bus.mac_rx_data = frm[48];
        @(negedge mac_clk);
        chk("midrst_dvld",    {63'd0, bus.app_dvld}, 64'd0);
        chk("midrst_data",    {56'd0, bus.app_data}, 64'd0);
        chk("midrst_srcip",   {32'd0, bus.app_srcip}, 64'd0);
        chk("midrst_srcport", {48'd0, bus.app_srcport}, 64'd0);
        chk("midrst_drop",    {48'd0, bus.rx_drop_count}, 64'd0);
        exp_drop = 0;
        for (int i = 49; i < 52; i++) begin
            @(posedge mac_clk); #1;
            bus.mac_rx_data = frm[i];
        end
        mac_rst_n = 1'b1;
        for (int i = 52; i < frm.size(); i++) begin
            @(posedge mac_clk); #1;
            bus.mac_rx_data = frm[i];
        end
        @(posedge mac_clk); #1;
        bus.mac_rx_dvld      = 1'b0;
        bus.mac_rx_goodframe = 1'b1;
        @(posedge mac_clk); #1;
        bus.mac_rx_goodframe = 1'b0;
        settle_and_check("resync");

        build(MYMAC, 8'h11, MYIP, PORT, 16'd40, 8'h60, 1'b0);
        push_exp(8'h60, 32, 1'b1);
        send(frm.size(), 1);
        settle_and_check("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gbe_rx_udp.md
# gbe_rx_udp

Receive-side UDP/IPv4 parser for the 1GbE core. Consumes the MAC receive byte stream, validates the Ethernet, IPv4 and UDP headers against the local configuration, and forwards only the UDP payload to the application with source IP and port attached. It sits between the MAC receive port and the application receive interface, in the `mac_clk` domain, and is the receive counterpart of the existing UDP transmit path.

## Interface
- `ACCEPT_BCAST`, default 1: when 1, a destination MAC of ff:ff:ff:ff:ff:ff is accepted in addition to `local_mac`.
- `mac_clk`  in  1  byte clock; all logic runs on its rising edge.
- `mac_rst_n`  in  1  asynchronous, active-low reset.
- `mac_rx_data`  in  8  received frame byte, preamble and SFD already stripped.
- `mac_rx_dvld`  in  1  `mac_rx_data` valid; contiguous high for the whole frame.
- `mac_rx_goodframe`  in  1  one-cycle pulse after the last byte: FCS good.
- `mac_rx_badframe`  in  1  one-cycle pulse after the last byte: FCS or PHY error.
- `local_enable`  in  1  quasi-static receive enable; sampled only in IDLE.
- `local_mac`  in  48  station MAC address.
- `local_ip`  in  32  station IP address.
- `local_port`  in  16  UDP port to accept.
- `app_data`  out  8  payload byte.
- `app_dvld`  out  1  `app_data` valid.
- `app_eof`  out  1  high with the last payload byte.
- `app_bad`  out  1  one-cycle pulse: the payload just delivered came from a bad or truncated frame.
- `app_srcip`  out  32  source IP; stable from the first `app_dvld` of a frame until the next frame's first `app_dvld`.
- `app_srcport`  out  16  source UDP port; same stability rule as `app_srcip`.
- `rx_drop_count`  out  16  frames rejected; saturates at 0xFFFF.

## Operation
- States: IDLE, HDR_MAC, HDR_IP, HDR_UDP, DATA, SKIP.
- IDLE: on the first `mac_rx_dvld` byte, go to HDR_MAC if `local_enable` is high, otherwise go to SKIP. A frame ignored because the block is disabled does not increment `rx_drop_count`.
- Header byte counter: 6 bits. It covers 14 bytes of MAC header, 20 bytes of IP header and 8 bytes of UDP header, and restarts at 0 on each header state entry.
- Checks, each registered as a sticky reject flag:
  - destination MAC matches `local_mac` (or broadcast when `ACCEPT_BCAST` is 1);
  - ethertype is 0x0800;
  - IP byte 0 is 0x45;
  - IP bytes 6–7 have fragment offset 0 and the MF bit clear;
  - protocol is 0x11;
  - destination IP equals `local_ip`;
  - destination port equals `local_port`;
  - UDP length is at least 8.
- At the last UDP header byte: if any reject flag is set, go to SKIP and increment `rx_drop_count`. Otherwise latch the source IP and source port, load the payload counter with UDP length − 8 (16 bits), and go to DATA. If the payload length is 0, go to SKIP without output or drop count.
- DATA: forward each byte and decrement the counter. On count 1, assert `app_eof` and go to SKIP.
- Bytes after the UDP length (Ethernet padding) are discarded in SKIP.
- SKIP: wait for `mac_rx_dvld` low, then go to IDLE.
- Frame end with payload already forwarded:
  - A `mac_rx_badframe` pulse gives `app_bad` one cycle later.
  - `mac_rx_dvld` falling in DATA before the count is exhausted is a truncation: `app_bad` pulses, no `app_eof` is emitted, `rx_drop_count` increments, and the state returns to IDLE.
- `mac_rx_dvld` falling in any header state: increment `rx_drop_count` and go to IDLE.

## Timing
- Reset values: `app_data` 0, `app_dvld` 0, `app_eof` 0, `app_bad` 0, `app_srcip` 0, `app_srcport` 0, `rx_drop_count` 0; state IDLE.
- Latency: all outputs are registered. Payload byte *n* appears on `app_data` one cycle after it appears on `mac_rx_data`.
- No back-pressure: `app_dvld` follows the MAC exactly, one byte per cycle.
- Back-to-back frames: one idle cycle (`mac_rx_dvld` low) between frames is sufficient. The good/bad pulse may coincide with the next frame's first byte.
- Reset asserted mid-frame clears the state immediately. On release, the block resynchronises by waiting for `mac_rx_dvld` low (enter SKIP if it is high).

## Configuration
- `GBE_RX_CSUM_EN` defined:
  - The ones-complement sum of the ten 16-bit IP header words, with end-around carry, is accumulated during HDR_IP.
  - A result other than 0xFFFF sets a reject flag.
  - The comparison completes before the last UDP header byte, so no extra latency is added.
- `GBE_RX_CSUM_EN` undefined: the IP checksum is ignored, and no adder logic is instantiated.

## Test plan
- Valid frame to `local_ip` 10.0.0.2, port 7148, 32-byte payload, good FCS → 32 `app_dvld` cycles; `app_eof` on byte 32; `app_srcip` and `app_srcport` match the header; `app_bad` stays 0; `rx_drop_count` stays 0.
- Same frame with the wrong destination port, then the wrong destination MAC, then protocol 0x06 → no `app_dvld`; `rx_drop_count` equals 3.
- UDP length 12 (4-byte payload) inside a 60-byte padded frame → exactly 4 bytes forwarded with `app_eof` on the 4th; padding is not forwarded.
- Valid frame ended with `mac_rx_badframe` → full payload delivered, then an `app_bad` pulse 1 cycle after the pulse; then `mac_rx_dvld` dropped after 10 of 32 payload bytes → 10 bytes delivered, `app_bad` pulses, no `app_eof`, drop count +1.
- With `GBE_RX_CSUM_EN` defined, a corrupted IP checksum → frame dropped and count +1; without the macro → frame delivered.
- `mac_rst_n` asserted mid-payload, then released while `mac_rx_dvld` is still high → outputs are 0; the remainder of that frame is ignored; the next frame is received normally.
